// File: rtl/axi4_burst_csr_slave_if.sv
// axi4_burst_csr_slave_if: AXI4 bus (32-bit data) between the PS GP master and the CSR slave
// Groups: aw* write address, w* write data, b* write response, ar* read address, r* read data
interface axi4_burst_csr_slave_if #(
    parameter int ID_W   = 12,
    parameter int ADDR_W = 32
);
    logic              awvalid, awready;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [ID_W-1:0]   awid;
    logic              wvalid, wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              bvalid, bready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              arvalid, arready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [ID_W-1:0]   arid;
    logic              rvalid, rready;
    logic [ID_W-1:0]   rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, awid,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
        output awready, wready, bvalid, bid, bresp,
        output arready, rvalid, rid, rdata, rresp, rlast
    );

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, awid,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, araddr, arlen, arsize, arburst, arid, rready,
        input  awready, wready, bvalid, bid, bresp,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/axi4_burst_csr_slave.sv
// axi4_burst_csr_slave: AXI4 INCR/FIXED burst slave over a CSR file with a maskable level IRQ aggregator
// Ports: clk; reset (sync, active-high); bus (AXI4 slave modport); irq_src (N_IRQ sources);
//        csr_out (reg i at [32*i+:32]); irq (registered |(IRQ_STATUS & IRQ_ENABLE))
module axi4_burst_csr_slave #(
    parameter int          ID_W    = 12,
    parameter int          ADDR_W  = 32,
    parameter int          N_REGS  = 16,
    parameter int          N_IRQ   = 8,
    parameter logic [31:0] VERSION = 32'h0001_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    axi4_burst_csr_slave_if.slave  bus,
    input  logic [N_IRQ-1:0]       irq_src,
    output logic [32*N_REGS-1:0]   csr_out,
    output logic                   irq
);
    localparam int          IDX_W = $clog2(N_REGS);
    localparam logic [31:0] IRQ_M = 32'((64'd1 << N_IRQ) - 64'd1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    w_state_t         w_state, w_next;
    r_state_t         r_state, r_next;
    logic [31:0]      regs [N_REGS];
    logic [IDX_W-1:0] widx, ridx, ld_idx;
    logic [7:0]       wlen, wcnt, rlen, rcnt;
    logic             wbad, wfixed, rbad, rfixed;
    logic             aw_hs, w_hs, ar_hs, r_hs, w_err, wr_en, beat_err, ld_err;
    logic [31:0]      bmask, w1c, ld_word;

    // Only 32-bit beats with INCR or FIXED bursts are serviced.
    function automatic logic bad_fmt(input logic [2:0] sz, input logic [1:0] bt);
        return sz != 3'd2 || bt[1];
    endfunction

    assign bus.awready = w_state == W_IDLE;
    assign bus.wready  = w_state == W_DATA;
    assign bus.bvalid  = w_state == W_RESP;
    assign bus.arready = r_state == R_IDLE;
    assign bus.rvalid  = r_state == R_DATA;

    always_comb begin
        aw_hs    = w_state == W_IDLE && bus.awvalid;
        w_hs     = w_state == W_DATA && bus.wvalid;
        ar_hs    = r_state == R_IDLE && bus.arvalid;
        r_hs     = r_state == R_DATA && bus.rready;
        w_err    = wbad || int'(widx) >= N_REGS;
        wr_en    = w_hs && !w_err;
        beat_err = w_err || (bus.wlast != (wcnt == wlen));
        bmask    = {{8{bus.wstrb[3]}}, {8{bus.wstrb[2]}}, {8{bus.wstrb[1]}}, {8{bus.wstrb[0]}}};
        w1c      = (wr_en && widx == IDX_W'(1)) ? bus.wdata & bmask : '0;
        // Index of the beat loaded into the read output registers on this edge.
        ld_idx   = ar_hs ? bus.araddr[IDX_W+1:2] : (rfixed ? ridx : ridx + 1'b1);
        ld_err   = (ar_hs ? bad_fmt(bus.arsize, bus.arburst) : rbad) || int'(ld_idx) >= N_REGS;
        ld_word  = '0;
        for (int i = 0; i < N_REGS; i++) if (int'(ld_idx) == i) ld_word = regs[i];
        w_next = w_state;
        if (aw_hs) w_next = W_DATA;
        if (w_hs && wcnt == wlen) w_next = W_RESP;
        if (w_state == W_RESP && bus.bready) w_next = W_IDLE;
        r_next = r_state;
        if (ar_hs) r_next = R_DATA;
        if (r_hs && bus.rlast) r_next = R_IDLE;
        csr_out = '0;
        for (int i = 0; i < N_REGS; i++) csr_out[32*i +: 32] = regs[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // Write channel: bresp accumulates beat errors across the burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.bid   <= '0;
            bus.bresp <= 2'b00;
            widx      <= '0;
            wlen      <= '0;
            wcnt      <= '0;
            wbad      <= 1'b0;
            wfixed    <= 1'b0;
        end else if (aw_hs) begin
            bus.bid   <= bus.awid;
            bus.bresp <= 2'b00;
            widx      <= bus.awaddr[IDX_W+1:2];
            wlen      <= bus.awlen;
            wcnt      <= '0;
            wbad      <= bad_fmt(bus.awsize, bus.awburst);
            wfixed    <= bus.awburst == 2'b00;
        end else if (w_hs) begin
            wcnt <= wcnt + 8'd1;
            widx <= wfixed ? widx : widx + 1'b1;
            if (beat_err) bus.bresp <= 2'b10;
        end
    end

    // Read channel: next beat is loaded on the same edge as the current handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rid   <= '0;
            bus.rdata <= '0;
            bus.rresp <= 2'b00;
            bus.rlast <= 1'b0;
            ridx      <= '0;
            rlen      <= '0;
            rcnt      <= '0;
            rbad      <= 1'b0;
            rfixed    <= 1'b0;
        end else begin
            if (ar_hs) begin
                bus.rid <= bus.arid;
                rlen    <= bus.arlen;
                rcnt    <= '0;
                rbad    <= bad_fmt(bus.arsize, bus.arburst);
                rfixed  <= bus.arburst == 2'b00;
            end else if (r_hs) begin
                rcnt <= rcnt + 8'd1;
            end
            if (ar_hs || (r_hs && !bus.rlast)) begin
                ridx      <= ld_idx;
                bus.rdata <= ld_err ? '0 : ld_word;
                bus.rresp <= ld_err ? 2'b10 : 2'b00;
                bus.rlast <= ar_hs ? bus.arlen == '0 : (rcnt + 8'd1) == rlen;
            end else if (r_hs) begin
                bus.rlast <= 1'b0;
            end
        end
    end

    // CSR file; a source asserted in the same cycle as a W1C keeps its status bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_REGS; i++) regs[i] <= (i == 0) ? VERSION : '0;
            irq <= 1'b0;
        end else begin
            regs[1] <= ((regs[1] & ~w1c) | 32'(irq_src)) & IRQ_M;
            for (int i = 2; i < N_REGS; i++)
                if (wr_en && int'(widx) == i)
                    regs[i] <= (regs[i] & ~bmask) | (bus.wdata & bmask & ((i == 2) ? IRQ_M : 32'hFFFF_FFFF));
            irq <= |(regs[1] & regs[2]);
        end
    end
endmodule
